// File: rtl/pcs_am_pkg.sv
// Alignment-marker definitions shared by the transmit AM inserter and the receive AM lock block.
// Holds the per-lane marker table, sync-header codes, lane count and BIP bit mapping.
package pcs_am_pkg;

  localparam int LEN_CODED_BLOCK = 66;
  localparam int N_LANES         = 20;
  localparam int NB_LANE_ID      = $clog2(N_LANES);
  localparam int NB_BIP          = 8;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic {
    AM_INSERT = 1'b0,
    DATA_PASS = 1'b1
  } am_state_e;

  // {M0, M1, M2} per PCS lane, 100GBASE-R lane marker table.
  localparam logic [23:0] AM_TABLE [N_LANES] = '{
    24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
    24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
    24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
    24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
  };

  function automatic logic [23:0] am_lane_marker(input logic [NB_LANE_ID-1:0] lane);
    am_lane_marker = '0;
    if (int'(lane) < N_LANES) am_lane_marker = AM_TABLE[lane];
  endfunction

  // BIP bit k covers payload bit (7-k) of every byte, i.e. block bit 63-k-8m.
  function automatic logic [6:0] bip_bit_pos(input int k, input int m);
    return 7'(63 - k - 8 * m);
  endfunction

  function automatic logic [LEN_CODED_BLOCK-1:0] am_block(input logic [NB_LANE_ID-1:0] lane,
                                                          input logic [NB_BIP-1:0]     bip);
    logic [23:0] m;
    m = am_lane_marker(lane);
    return {SH_CTRL, m, bip, ~m, ~bip};
  endfunction

endpackage

// File: rtl/am_insertion_module_if.sv
// Block stream through the AM inserter: upstream blocks in, data/AM blocks with lane tags out.
// Handshake: an input block transfers on a rising clock edge where i_valid && o_ready; the output
// side has no backpressure, so o_data/o_am_flag/o_lane_id are meaningful whenever o_valid is high.
interface am_insertion_module_if;

  logic                                   i_valid;
  logic [pcs_am_pkg::LEN_CODED_BLOCK-1:0] i_data;
  logic                                   o_ready;
  logic [pcs_am_pkg::LEN_CODED_BLOCK-1:0] o_data;
  logic                                   o_valid;
  logic                                   o_am_flag;
  logic [pcs_am_pkg::NB_LANE_ID-1:0]      o_lane_id;

  modport master (
    output i_valid,
    output i_data,
    input  o_ready,
    input  o_data,
    input  o_valid,
    input  o_am_flag,
    input  o_lane_id
  );

  modport slave (
    input  i_valid,
    input  i_data,
    output o_ready,
    output o_data,
    output o_valid,
    output o_am_flag,
    output o_lane_id
  );

endinterface

// File: rtl/am_insertion_module_bip_calculator.sv
// Combinational BIP contribution of one 66-bit block: byte-interleaved parity of the payload
// with the two sync-header bits folded into BIP bits 3 and 4.
module bip_calculator
  import pcs_am_pkg::*;
(
  input  logic [LEN_CODED_BLOCK-1:0] i_block,
  output logic [NB_BIP-1:0]          o_bip
);

  always_comb begin
    o_bip = '0;
    for (int k = 0; k < NB_BIP; k++) begin
      for (int m = 0; m < 8; m++) begin
        o_bip[k] = o_bip[k] ^ i_block[bip_bit_pos(k, m)];
      end
    end
    o_bip[3] = o_bip[3] ^ i_block[LEN_CODED_BLOCK-1];
    o_bip[4] = o_bip[4] ^ i_block[LEN_CODED_BLOCK-2];
  end

endmodule

// File: rtl/am_insertion_module.sv
// Transmit-side alignment-marker inserter: a group of N_LANES AMs carrying per-lane BIP,
// then N_BLOCKS*N_LANES forwarded data blocks, repeated; outputs are registered.
module am_insertion_module
  import pcs_am_pkg::*;
#(
  parameter int N_BLOCKS = 16383
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  am_insertion_module_if.slave bus,
  output am_state_e            o_state
);

  localparam int                      GROUP_BLOCKS = N_BLOCKS * N_LANES;
  localparam int                      NB_DATA_CNT  = $clog2(GROUP_BLOCKS);
  localparam logic [NB_DATA_CNT-1:0]  LAST_DATA    = NB_DATA_CNT'(GROUP_BLOCKS - 1);
  localparam logic [NB_LANE_ID-1:0]   LAST_LANE    = NB_LANE_ID'(N_LANES - 1);

  am_state_e                  state;
  logic [NB_LANE_ID-1:0]      lane_ptr;
  logic [NB_DATA_CNT-1:0]     data_cnt;
  logic [NB_BIP-1:0]          bip_acc [N_LANES];
  logic [NB_BIP-1:0]          lane_bip;
  logic [NB_BIP-1:0]          next_bip;
  logic [LEN_CODED_BLOCK-1:0] next_block;
  logic                       in_am;
  logic                       emit;

  // AM_INSERT emits unconditionally; DATA_PASS only on accepted blocks, never a bubble fill.
  assign in_am       = (state == AM_INSERT);
  assign emit        = i_enable && (in_am || bus.i_valid);
  assign lane_bip    = bip_acc[lane_ptr];
  assign next_block  = in_am ? am_block(lane_ptr, lane_bip) : bus.i_data;
  assign bus.o_ready = i_enable && i_reset && !in_am;
  assign o_state     = state;

  bip_calculator u_bip_calculator (
    .i_block (next_block),
    .o_bip   (next_bip)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= AM_INSERT;
      lane_ptr      <= '0;
      data_cnt      <= '0;
      bus.o_data    <= '0;
      bus.o_valid   <= 1'b0;
      bus.o_am_flag <= 1'b0;
      bus.o_lane_id <= '0;
    end else begin
      bus.o_valid   <= emit;
      bus.o_am_flag <= emit && in_am;
      if (emit) begin
        bus.o_data    <= next_block;
        bus.o_lane_id <= lane_ptr;
        lane_ptr      <= (lane_ptr == LAST_LANE) ? '0 : lane_ptr + 1'b1;
        // Group length is a multiple of N_LANES, so lane_ptr wraps to 0 on every state change.
        case (state)
          AM_INSERT: begin
            if (lane_ptr == LAST_LANE) state <= DATA_PASS;
          end
          DATA_PASS: begin
            if (data_cnt == LAST_DATA) begin
              data_cnt <= '0;
              state    <= AM_INSERT;
            end else begin
              data_cnt <= data_cnt + 1'b1;
            end
          end
          default: state <= AM_INSERT;
        endcase
      end
    end
  end

  // An AM reloads its lane's accumulator with its own parity, so the next BIP covers it.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int l = 0; l < N_LANES; l++) bip_acc[l] <= '0;
    end else if (emit) begin
      bip_acc[lane_ptr] <= in_am ? next_bip : (lane_bip ^ next_bip);
    end
  end

endmodule

// File: tb/tb_am_insertion_module.sv
// Directed bench for am_insertion_module: cycle vectors on an N_BLOCKS=1 instance, plus
// hand-written async-reset and N_BLOCKS=2 sequences.
module tb_am_insertion_module;
  import pcs_am_pkg::*;

  typedef struct {
    logic        en;
    logic        vld;
    logic [65:0] din;
    logic        e_valid;
    logic        e_am;
    logic [4:0]  e_lane;
    logic [65:0] e_data;
    logic        e_ready;
  } vec_t;

  localparam logic [23:0] LANE_M [20] = '{
    24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
    24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
    24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
    24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
  };
  localparam logic [65:0] ZERO_DATA    = {2'b01, 64'h0};
  localparam logic [65:0] FIRST_AM     = 66'h2_C168_2100_3E97_DEFF;
  localparam logic [65:0] LAST_AM      = 66'h2_C0F0_E500_3F0F_1AFF;
  localparam logic [65:0] AM0_EVEN_GRP = 66'h2_C168_2108_3E97_DEF7;
  localparam logic [65:0] AM0_ODD_GRP  = 66'h2_C168_2118_3E97_DEE7;

  // clock / reset
  logic      clk = 1'b0;
  logic      rst_a_n;
  logic      rst_b_n;
  logic      en_a;
  logic      en_b;
  am_state_e state_a;
  am_state_e state_b;

  always #5 clk = ~clk;

  am_insertion_module_if a_if ();
  am_insertion_module_if b_if ();

  am_insertion_module #(.N_BLOCKS(1)) dut_a (
    .i_clock  (clk),
    .i_reset  (rst_a_n),
    .i_enable (en_a),
    .bus      (a_if),
    .o_state  (state_a)
  );

  am_insertion_module #(.N_BLOCKS(2)) dut_b (
    .i_clock  (clk),
    .i_reset  (rst_b_n),
    .i_enable (en_b),
    .bus      (b_if),
    .o_state  (state_b)
  );

  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[$];
  logic [65:0] rand_blk [20];
  logic [65:0] blk;

  function automatic logic [65:0] exp_am(input int lane, input logic [7:0] bip);
    logic [23:0] m;
    m = LANE_M[lane];
    return {2'b10, m, bip, ~m, ~bip};
  endfunction

  // Byte-fold the payload, bit-reverse into BIP order, then add the sync header bits.
  function automatic logic [7:0] exp_bip(input logic [65:0] b);
    logic [7:0] fold;
    logic [7:0] r;
    fold = 8'h00;
    for (int i = 0; i < 8; i++) fold = fold ^ b[i*8 +: 8];
    for (int k = 0; k < 8; k++) r[k] = fold[7-k];
    r[3] = r[3] ^ b[65];
    r[4] = r[4] ^ b[64];
    return r;
  endfunction

  function automatic logic [65:0] junk();
    return {2'b01, 32'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [65:0] rand_block();
    logic [1:0] sh;
    sh = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
    return {sh, 32'($urandom), 32'($urandom)};
  endfunction

  // scoreboard
  task automatic check(input string name, input int idx, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int idx,
                           input logic valid, input logic ready, input logic am,
                           input logic [4:0] lane, input logic [65:0] data,
                           input logic ev, input logic er, input logic eam,
                           input logic [4:0] elane, input logic [65:0] edata);
    check({name, ".valid"}, idx, 66'(valid), 66'(ev));
    check({name, ".ready"}, idx, 66'(ready), 66'(er));
    if (ev) begin
      check({name, ".am_flag"}, idx, 66'(am), 66'(eam));
      check({name, ".lane_id"}, idx, 66'(lane), 66'(elane));
      check({name, ".data"}, idx, data, edata);
    end
  endtask

  // driver helpers
  task automatic add_vec(input logic en, input logic vld, input logic [65:0] din,
                         input logic ev, input logic eam, input int lane,
                         input logic [65:0] ed, input logic er);
    vec_t v;
    v.en      = en;
    v.vld     = vld;
    v.din     = din;
    v.e_valid = ev;
    v.e_am    = eam;
    v.e_lane  = 5'(lane);
    v.e_data  = ed;
    v.e_ready = er;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    logic [65:0] am_exp;
    // group 1 right after reset: BIP 0, i_valid high but ignored
    for (int l = 0; l < 20; l++) begin
      am_exp = (l == 0) ? FIRST_AM : ((l == 19) ? LAST_AM : exp_am(l, 8'h00));
      add_vec(1'b1, 1'b1, junk(), 1'b1, 1'b1, l, am_exp, l == 19);
    end
    // 20 all-zero data blocks, lanes 0..19
    for (int k = 0; k < 20; k++)
      add_vec(1'b1, 1'b1, ZERO_DATA, 1'b1, 1'b0, k, ZERO_DATA, k != 19);
    // group 2: each lane saw AM (08) + zero block (10); freeze 5 cycles after the lane-7 AM
    for (int l = 0; l < 20; l++) begin
      am_exp = (l == 0) ? AM0_ODD_GRP : exp_am(l, 8'h18);
      add_vec(1'b1, 1'b1, junk(), 1'b1, 1'b1, l, am_exp, l == 19);
      if (l == 7) begin
        for (int f = 0; f < 5; f++) add_vec(1'b0, 1'b1, junk(), 1'b0, 1'b0, 0, '0, 1'b0);
      end
    end
    // backpressure: valid on even slots only, random blocks
    for (int j = 0; j < 39; j++) begin
      if (j % 2 == 0) begin
        rand_blk[j/2] = rand_block();
        add_vec(1'b1, 1'b1, rand_blk[j/2], 1'b1, 1'b0, j / 2, rand_blk[j/2], j != 38);
      end else begin
        add_vec(1'b1, 1'b0, junk(), 1'b0, 1'b0, 0, '0, 1'b1);
      end
    end
    // group 3: BIP = previous AM contribution (08) ^ the lane's random block
    for (int l = 0; l < 20; l++)
      add_vec(1'b1, 1'b0, junk(), 1'b1, 1'b1, l, exp_am(l, 8'h08 ^ exp_bip(rand_blk[l])), l == 19);
  endtask

  initial begin
    rst_a_n      = 1'b0;
    rst_b_n      = 1'b0;
    en_a         = 1'b1;
    en_b         = 1'b1;
    a_if.i_valid = 1'b0;
    a_if.i_data  = '0;
    b_if.i_valid = 1'b1;
    b_if.i_data  = ZERO_DATA;
    build_table();

    // reset values on both instances
    repeat (3) @(negedge clk);
    check_out("reset_a", 0, a_if.o_valid, a_if.o_ready, a_if.o_am_flag, a_if.o_lane_id, a_if.o_data,
              1'b0, 1'b0, 1'b0, 5'd0, '0);
    check("reset_a.data", 0, a_if.o_data, '0);
    check("reset_a.lane_id", 0, 66'(a_if.o_lane_id), '0);
    check("reset_a.am_flag", 0, 66'(a_if.o_am_flag), '0);
    check("reset_a.state", 0, 66'(state_a), 66'(AM_INSERT));
    check("reset_b.valid", 0, 66'(b_if.o_valid), '0);
    check("reset_b.ready", 0, 66'(b_if.o_ready), '0);
    check("reset_b.state", 0, 66'(state_b), 66'(AM_INSERT));

    // table-driven run on the N_BLOCKS=1 instance
    rst_a_n = 1'b1;
    foreach (vecs[i]) begin
      en_a         = vecs[i].en;
      a_if.i_valid = vecs[i].vld;
      a_if.i_data  = vecs[i].din;
      @(posedge clk); #1;
      check_out("vec", i, a_if.o_valid, a_if.o_ready, a_if.o_am_flag, a_if.o_lane_id, a_if.o_data,
                vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_am, vecs[i].e_lane, vecs[i].e_data);
      @(negedge clk);
    end

    // a few data blocks, then asynchronous reset between clock edges
    en_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      blk          = rand_block();
      a_if.i_valid = 1'b1;
      a_if.i_data  = blk;
      @(posedge clk); #1;
      check_out("pre_reset", k, a_if.o_valid, a_if.o_ready, a_if.o_am_flag, a_if.o_lane_id, a_if.o_data,
                1'b1, 1'b1, 1'b0, 5'(k), blk);
      @(negedge clk);
    end
    a_if.i_data = rand_block();
    @(posedge clk); #3;
    rst_a_n = 1'b0;
    #1;
    check("async_rst.valid", 0, 66'(a_if.o_valid), '0);
    check("async_rst.data", 0, a_if.o_data, '0);
    check("async_rst.am_flag", 0, 66'(a_if.o_am_flag), '0);
    check("async_rst.lane_id", 0, 66'(a_if.o_lane_id), '0);
    check("async_rst.ready", 0, 66'(a_if.o_ready), '0);
    @(negedge clk);
    rst_a_n = 1'b1;
    @(posedge clk); #1;
    check_out("post_reset", 0, a_if.o_valid, a_if.o_ready, a_if.o_am_flag, a_if.o_lane_id, a_if.o_data,
              1'b1, 1'b0, 1'b1, 5'd0, FIRST_AM);

    // N_BLOCKS=2 instance: continuous zero blocks; 20 AMs, 40 data, 20 AMs with BIP 08
    @(negedge clk);
    rst_b_n = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (c < 20) begin
        check_out("even_grp1", c, b_if.o_valid, b_if.o_ready, b_if.o_am_flag, b_if.o_lane_id, b_if.o_data,
                  1'b1, c == 19, 1'b1, 5'(c), exp_am(c, 8'h00));
      end else if (c < 60) begin
        check_out("even_data", c, b_if.o_valid, b_if.o_ready, b_if.o_am_flag, b_if.o_lane_id, b_if.o_data,
                  1'b1, c != 59, 1'b0, 5'((c - 20) % 20), ZERO_DATA);
      end else begin
        check_out("even_grp2", c, b_if.o_valid, b_if.o_ready, b_if.o_am_flag, b_if.o_lane_id, b_if.o_data,
                  1'b1, c == 79, 1'b1, 5'(c - 60),
                  (c == 60) ? AM0_EVEN_GRP : exp_am(c - 60, 8'h08));
      end
      @(negedge clk);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
